// File: rtl/rf_pkg.sv
// rf_pkg
// Shared defaults for the multiport register file and the address-width
// derivation used by the interface and the top.
//   RF_WIDTH : data bits per register
//   RF_DEPTH : general-purpose registers (F sits at index RF_DEPTH)
//   RF_NRD   : independent read ports
//   rf_aw()  : address width able to index 0..depth (F included)
package rf_pkg;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 4;
  localparam int RF_NRD   = 2;

  function automatic int rf_aw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if
// Bus bundle between a register-file user (master) and rf_multiport (slave).
//   we/waddr/wdata     : general write port
//   f_we/f_mask/f_d    : masked flag update from the ALU path
//   re/raddr           : per-port read request, packed indices (AW bits/port)
//   rdata/rvalid       : packed registered read data and per-port valid
//   fo                 : current flag register contents
//   err                : sticky out-of-range access indication
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD
);

  localparam int AW = rf_aw(DEPTH);

  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WIDTH-1:0]     wdata;
  logic                 f_we;
  logic [WIDTH-1:0]     f_mask;
  logic [WIDTH-1:0]     f_d;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*WIDTH-1:0] rdata;
  logic [NRD-1:0]       rvalid;
  logic [WIDTH-1:0]     fo;
  logic                 err;

  modport master (
    output we, waddr, wdata, f_we, f_mask, f_d, re, raddr,
    input  rdata, rvalid, fo, err
  );

  modport slave (
    input  we, waddr, wdata, f_we, f_mask, f_d, re, raddr,
    output rdata, rvalid, fo, err
  );

endinterface

// File: rtl/rf_entry.sv
// rf_entry
// One WIDTH-bit storage element with asynchronous active-high reset.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, clears q
//   ld   : load enable
//   mask : per-bit select, 1 = take d, 0 = hold
//   d    : load data
//   q    : stored value
module rf_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= (q & ~mask) | (d & mask);
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport
// DEPTH general registers plus a flag register F at index DEPTH, one write
// port, a masked flag-update port and NRD independent registered read ports.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears storage, read outputs, err)
//   bus : rf_multiport_if slave modport carrying write, flag, read, fo, err
// Reads are write-first: each port samples the value the addressed entry
// will hold after this edge. Out-of-range indices read as zero and set err.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NRD   = RF_NRD
) (
  input  logic         clk,
  input  logic         rst,
  rf_multiport_if.slave bus
);

  localparam int AW    = rf_aw(DEPTH);
  // Read mux covers every encodable index; slots above DEPTH are zero so an
  // out-of-range read naturally returns zeros.
  localparam int NSLOT = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH);

  logic [WIDTH-1:0] slot_next [NSLOT];
  logic [WIDTH-1:0] f_q;
  logic [NRD:0]     oob;
  logic             err_reg;

  // Storage entries and their post-edge (write-first) view.
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi <= DEPTH) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic             wr_hit;
      logic             ld;
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] q;

      assign wr_hit = bus.we && (bus.waddr == IDX);

      if (gi == DEPTH) begin : g_flag
        // Flag update owns its masked bits; a concurrent general write to F
        // fills only the remaining bits.
        logic [WIDTH-1:0] fmask;
        assign fmask = bus.f_we ? bus.f_mask : '0;
        assign ld    = wr_hit | bus.f_we;
        assign mask  = {WIDTH{wr_hit}} | fmask;
        assign d     = (bus.f_d & fmask) | (bus.wdata & ~fmask);
        assign f_q   = q;
      end else begin : g_gp
        assign ld   = wr_hit;
        assign mask = '1;
        assign d    = bus.wdata;
      end

      rf_entry #(.WIDTH(WIDTH)) u_entry (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .mask (mask),
        .d    (d),
        .q    (q)
      );

      assign slot_next[gi] = ld ? ((q & ~mask) | (d & mask)) : q;
    end else begin : g_pad
      assign slot_next[gi] = '0;
    end
  end

  assign oob[NRD] = bus.we && (bus.waddr > LAST_IDX);

  // Read ports.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rdata_reg;
    logic             rvalid_reg;

    assign ra      = bus.raddr[gi*AW +: AW];
    assign oob[gi] = bus.re[gi] && (ra > LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
      end else begin
        rvalid_reg <= bus.re[gi];
        if (bus.re[gi]) begin
          rdata_reg <= slot_next[ra];
        end
      end
    end

    assign bus.rdata[gi*WIDTH +: WIDTH] = rdata_reg;
    assign bus.rvalid[gi]               = rvalid_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (|oob) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
  assign bus.fo  = f_q;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport
// Directed scenarios for rf_multiport with hand-computed expectations.
module tb_rf_multiport;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  rf_multiport_if #(.WIDTH(8), .DEPTH(4), .NRD(2)) bus ();

  rf_multiport #(.WIDTH(8), .DEPTH(4), .NRD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic idle();
    bus.we     = 1'b0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.f_we   = 1'b0;
    bus.f_mask = '0;
    bus.f_d    = '0;
    bus.re     = '0;
    bus.raddr  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    idle();
    bus.we = 1'b1; bus.waddr = a; bus.wdata = v;
    tick();
    $display("[%0t] write r%0d = %h", $time, a, v);
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 8'hFF; bus.re = 2'b01;
    repeat (2) tick();
    rst = 1'b0;
    idle();
    $display("[%0t] reset released", $time);
    checks++; if (bus.rdata !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", bus.rdata); else passed++;
    checks++; if (bus.rvalid !== 2'b00) $display("FAIL reset_rvalid got %b want 00", bus.rvalid); else passed++;
    checks++; if (bus.fo !== 8'h00) $display("FAIL reset_fo got %h want 00", bus.fo); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else passed++;
    bus.re = 2'b01; bus.raddr = 6'd0;
    tick();
    $display("[%0t] read p0 r0 -> %h", $time, bus.rdata[7:0]);
    checks++; if (bus.rdata[7:0] !== 8'h00) $display("FAIL reset_discard_wr got %h want 00", bus.rdata[7:0]); else passed++;
    checks++; if (bus.rvalid[0] !== 1'b1) $display("FAIL first_op_rvalid got %b want 1", bus.rvalid[0]); else passed++;
    idle();
  endtask

  task automatic test_write_read();
    wr(3'd2, 8'hA5);
    bus.re = 2'b01; bus.raddr = {3'd0, 3'd2};
    checks++; if (bus.rvalid[0] !== 1'b0) $display("FAIL wr_rd_pre_rvalid got %b want 0", bus.rvalid[0]); else passed++;
    tick();
    $display("[%0t] read p0 r2 -> %h", $time, bus.rdata[7:0]);
    checks++; if (bus.rdata[7:0] !== 8'hA5) $display("FAIL wr_rd_data got %h want a5", bus.rdata[7:0]); else passed++;
    checks++; if (bus.rvalid[0] !== 1'b1) $display("FAIL wr_rd_rvalid got %b want 1", bus.rvalid[0]); else passed++;
    idle();
  endtask

  task automatic test_bypass();
    bus.we = 1'b1; bus.waddr = 3'd1; bus.wdata = 8'h3C;
    bus.re = 2'b10; bus.raddr = {3'd1, 3'd0};
    tick();
    $display("[%0t] write r1=3c + read p1 r1 -> %h", $time, bus.rdata[15:8]);
    checks++; if (bus.rdata[15:8] !== 8'h3C) $display("FAIL bypass_data got %h want 3c", bus.rdata[15:8]); else passed++;
    checks++; if (bus.rvalid !== 2'b10) $display("FAIL bypass_rvalid got %b want 10", bus.rvalid); else passed++;
    idle();
  endtask

  task automatic test_flag_merge();
    bus.we = 1'b1; bus.waddr = 3'd4; bus.wdata = 8'hFF;
    bus.f_we = 1'b1; bus.f_mask = 8'h0F; bus.f_d = 8'h00;
    bus.re = 2'b01; bus.raddr = {3'd0, 3'd4};
    #1;
    checks++; if (bus.fo !== 8'h00) $display("FAIL fo_no_bypass got %h want 00", bus.fo); else passed++;
    tick();
    $display("[%0t] write F=ff with f_mask=0f f_d=00 -> fo %h", $time, bus.fo);
    checks++; if (bus.fo !== 8'hF0) $display("FAIL flag_merge_fo got %h want f0", bus.fo); else passed++;
    checks++; if (bus.rdata[7:0] !== 8'hF0) $display("FAIL flag_merge_rd got %h want f0", bus.rdata[7:0]); else passed++;
    idle();
    bus.f_we = 1'b1; bus.f_mask = 8'h3C; bus.f_d = 8'h5A;
    tick();
    $display("[%0t] flag update mask=3c d=5a -> fo %h", $time, bus.fo);
    checks++; if (bus.fo !== 8'hD8) $display("FAIL flag_update_fo got %h want d8", bus.fo); else passed++;
    idle();
  endtask

  task automatic test_multi_port();
    bus.re = 2'b11; bus.raddr = {3'd2, 3'd2};
    tick();
    $display("[%0t] read p0 r2, p1 r2 -> %h %h", $time, bus.rdata[7:0], bus.rdata[15:8]);
    checks++; if (bus.rdata !== 16'hA5A5) $display("FAIL same_addr got %h want a5a5", bus.rdata); else passed++;
    bus.raddr = {3'd4, 3'd1};
    tick();
    $display("[%0t] read p0 r1, p1 F -> %h %h", $time, bus.rdata[7:0], bus.rdata[15:8]);
    checks++; if (bus.rdata !== 16'hD83C) $display("FAIL diff_addr got %h want d83c", bus.rdata); else passed++;
    checks++; if (bus.rvalid !== 2'b11) $display("FAIL diff_addr_rvalid got %b want 11", bus.rvalid); else passed++;
    idle();
  endtask

  task automatic test_hold();
    bus.re = 2'b01; bus.raddr = {3'd0, 3'd2};
    tick();
    $display("[%0t] read p0 r2 -> %h", $time, bus.rdata[7:0]);
    idle();
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 8'h11;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      $display("[%0t] idle cycle %0d, rdata0 %h", $time, i, bus.rdata[7:0]);
      checks++; if (bus.rdata[7:0] !== 8'hA5) $display("FAIL hold_data%0d got %h want a5", i, bus.rdata[7:0]); else passed++;
      checks++; if (bus.rvalid[0] !== 1'b0) $display("FAIL hold_rvalid%0d got %b want 0", i, bus.rvalid[0]); else passed++;
    end
    bus.re = 2'b01; bus.raddr = {3'd0, 3'd2};
    tick();
    $display("[%0t] read p0 r2 -> %h", $time, bus.rdata[7:0]);
    checks++; if (bus.rdata[7:0] !== 8'h11) $display("FAIL hold_reread got %h want 11", bus.rdata[7:0]); else passed++;
    idle();
  endtask

  task automatic test_oob_read();
    checks++; if (bus.err !== 1'b0) $display("FAIL oob_rd_pre_err got %b want 0", bus.err); else passed++;
    bus.re = 2'b01; bus.raddr = {3'd0, 3'd5};
    tick();
    $display("[%0t] read p0 idx5 -> %h err %b", $time, bus.rdata[7:0], bus.err);
    checks++; if (bus.rdata[7:0] !== 8'h00) $display("FAIL oob_rd_data got %h want 00", bus.rdata[7:0]); else passed++;
    checks++; if (bus.rvalid[0] !== 1'b1) $display("FAIL oob_rd_rvalid got %b want 1", bus.rvalid[0]); else passed++;
    checks++; if (bus.err !== 1'b1) $display("FAIL oob_rd_err got %b want 1", bus.err); else passed++;
    idle();
    repeat (3) tick();
    checks++; if (bus.err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.err); else passed++;
  endtask

  task automatic test_reset_mid_read();
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h22);
    wr(3'd2, 8'h33);
    wr(3'd3, 8'h44);
    wr(3'd4, 8'h55);
    bus.re = 2'b11; bus.raddr = {3'd3, 3'd0};
    tick();
    $display("[%0t] read p0 r0, p1 r3 -> %h", $time, bus.rdata);
    checks++; if (bus.rdata !== 16'h4411) $display("FAIL pre_rst_rd got %h want 4411", bus.rdata); else passed++;
    checks++; if (bus.fo !== 8'h55) $display("FAIL pre_rst_fo got %h want 55", bus.fo); else passed++;
    #3;
    rst = 1'b1;
    #1;
    $display("[%0t] reset asserted mid-cycle", $time);
    checks++; if (bus.rdata !== 16'h0000) $display("FAIL async_rst_rdata got %h want 0000", bus.rdata); else passed++;
    checks++; if (bus.rvalid !== 2'b00) $display("FAIL async_rst_rvalid got %b want 00", bus.rvalid); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL async_rst_err got %b want 0", bus.err); else passed++;
    checks++; if (bus.fo !== 8'h00) $display("FAIL async_rst_fo got %h want 00", bus.fo); else passed++;
    bus.we = 1'b1; bus.waddr = 3'd1; bus.wdata = 8'h99;
    tick();
    rst = 1'b0;
    idle();
    bus.re = 2'b11; bus.raddr = {3'd4, 3'd1};
    tick();
    $display("[%0t] read p0 r1, p1 F after reset -> %h", $time, bus.rdata);
    checks++; if (bus.rdata !== 16'h0000) $display("FAIL post_rst_rd got %h want 0000", bus.rdata); else passed++;
    checks++; if (bus.rvalid !== 2'b11) $display("FAIL post_rst_rvalid got %b want 11", bus.rvalid); else passed++;
    idle();
  endtask

  task automatic test_oob_write();
    wr(3'd0, 8'h77);
    bus.we = 1'b1; bus.waddr = 3'd7; bus.wdata = 8'hEE;
    checks++; if (bus.err !== 1'b0) $display("FAIL oob_wr_pre_err got %b want 0", bus.err); else passed++;
    tick();
    $display("[%0t] write idx7 = ee, err %b", $time, bus.err);
    checks++; if (bus.err !== 1'b1) $display("FAIL oob_wr_err got %b want 1", bus.err); else passed++;
    idle();
    bus.re = 2'b11; bus.raddr = {3'd4, 3'd0};
    tick();
    $display("[%0t] read p0 r0, p1 F -> %h", $time, bus.rdata);
    checks++; if (bus.rdata !== 16'h0077) $display("FAIL oob_wr_nochange got %h want 0077", bus.rdata); else passed++;
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_flag_merge();
    test_multi_port();
    test_hold();
    test_oob_read();
    test_reset_mid_read();
    test_oob_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
